// File: rtl/lcd_i2c_responder.sv
// ---------------------------------------------------------------------------
// lcd_i2c_responder
//   I2C slave emulating a PCF8574 LCD backpack. It ACKs writes to SLAVE_ADDR,
//   mirrors the written byte on port_q, and decodes HD44780 4-bit E strobes
//   into command/data bytes. SDA is driven open-drain through sda_out_en.
//
//   Optional feature macro: LCD_RESP_READ_EN
//     defined   : read addresses are ACKed and port_q is shifted out.
//     undefined : read addresses are NACKed, no read states exist.
//
// Ports
//   clk_1MHz    in   system clock, oversamples the bus
//   rst_n       in   asynchronous active-low reset
//   scl, sda    in   bus levels
//   sda_out_en  out  1 = pull SDA low
//   port_q      out  expander port (P0 RS, P1 RW, P2 E, P3 BL, P7..P4 D7..D4)
//   rx_data     out  decoded LCD byte
//   rx_cmd_data out  RS of decoded byte (0 command, 1 data)
//   rx_half     out  rx_data holds a lone high nibble
//   rx_valid    out  one-cycle qualifier for the rx_* outputs
//   busy        out  high between START and STOP
// ---------------------------------------------------------------------------
module lcd_i2c_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h27,
  parameter logic [7:0] PORT_RST   = 8'hFF
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_out_en,
  output logic [7:0] port_q,
  output logic [7:0] rx_data,
  output logic       rx_cmd_data,
  output logic       rx_half,
  output logic       rx_valid,
  output logic       busy
);

`ifdef LCD_RESP_READ_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE, S_READ, S_READ_ACK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;
`endif

  state_t     r_state;
  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_load;      // port_q loads r_shift on the next clock
  logic       r_dec;       // strobe decode runs on the next clock
  logic [7:0] r_prev_q;    // port_q value before the latest load
  logic       r_phase;     // 1 = high nibble captured, waiting for low nibble
  logic [3:0] r_hi;
  logic       r_rs;
`ifdef LCD_RESP_READ_EN
  logic       r_rd;
  logic [7:0] r_tx;
  logic       r_last;
  logic       r_mack;
`endif

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // Both conditions require SCL to be high on both sides of the SDA edge
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronizers reset to the idle-bus level so release makes no edge
      r_scl_s1    <= 1'b1;
      r_scl_s2    <= 1'b1;
      r_scl_d     <= 1'b1;
      r_sda_s1    <= 1'b1;
      r_sda_s2    <= 1'b1;
      r_sda_d     <= 1'b1;
      r_state     <= S_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_load      <= 1'b0;
      r_dec       <= 1'b0;
      r_prev_q    <= PORT_RST;
      r_phase     <= 1'b0;
      r_hi        <= 4'h0;
      r_rs        <= 1'b0;
      sda_out_en  <= 1'b0;
      port_q      <= PORT_RST;
      rx_data     <= 8'h00;
      rx_cmd_data <= 1'b0;
      rx_half     <= 1'b0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
`ifdef LCD_RESP_READ_EN
      r_rd        <= 1'b0;
      r_tx        <= 8'h00;
      r_last      <= 1'b0;
      r_mack      <= 1'b0;
`endif
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      rx_valid <= 1'b0;
      r_load   <= 1'b0;
      r_dec    <= 1'b0;

      if (r_load) begin
        port_q   <= r_shift;
        r_prev_q <= port_q;
        r_dec    <= 1'b1;
      end

      // E falling edge with RW low latches a nibble from the pre-strobe port
      if (r_dec && r_prev_q[2] && !port_q[2] && !r_prev_q[1]) begin
        if (!r_phase) begin
          r_hi    <= r_prev_q[7:4];
          r_rs    <= r_prev_q[0];
          r_phase <= 1'b1;
        end else begin
          rx_data     <= {r_hi, r_prev_q[7:4]};
          rx_cmd_data <= r_rs;
          rx_half     <= 1'b0;
          rx_valid    <= 1'b1;
          r_phase     <= 1'b0;
        end
      end

      if (w_start || w_stop) begin
        // A pending lone high nibble is flushed at any bus boundary
        if (r_phase) begin
          rx_data     <= {r_hi, 4'h0};
          rx_cmd_data <= r_rs;
          rx_half     <= 1'b1;
          rx_valid    <= 1'b1;
          r_phase     <= 1'b0;
        end
        sda_out_en <= 1'b0;
        busy       <= w_start;
        r_bitcnt   <= 3'd0;
        r_state    <= w_start ? S_ADDR : S_IDLE;
`ifdef LCD_RESP_READ_EN
        r_rd       <= 1'b0;
        r_last     <= 1'b0;
        r_mack     <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift  <= {r_shift[6:0], r_sda_s2};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              // r_shift[6:0] holds the address, the bit sampled now is R/W
              if (r_shift[6:0] == SLAVE_ADDR && !r_sda_s2) r_state <= S_ADDR_ACK;
`ifdef LCD_RESP_READ_EN
              else if (r_shift[6:0] == SLAVE_ADDR) begin
                r_state <= S_ADDR_ACK;
                r_rd    <= 1'b1;
              end
`endif
              else r_state <= S_IGNORE;
            end
          end
          // First SCL fall asserts the ACK, the second one releases it
          S_ADDR_ACK: if (w_scl_fall) begin
            if (!sda_out_en) sda_out_en <= 1'b1;
            else begin
              sda_out_en <= 1'b0;
              r_bitcnt   <= 3'd0;
              r_state    <= S_DATA;
`ifdef LCD_RESP_READ_EN
              if (r_rd) begin
                sda_out_en <= ~port_q[7];
                r_tx       <= {port_q[6:0], 1'b0};
                r_last     <= 1'b0;
                r_state    <= S_READ;
              end
`endif
            end
          end
          S_DATA: if (w_scl_rise) begin
            r_shift  <= {r_shift[6:0], r_sda_s2};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_DATA_ACK;
              r_load  <= 1'b1;
            end
          end
          S_DATA_ACK: if (w_scl_fall) begin
            if (!sda_out_en) sda_out_en <= 1'b1;
            else begin
              sda_out_en <= 1'b0;
              r_bitcnt   <= 3'd0;
              r_state    <= S_DATA;
            end
          end
`ifdef LCD_RESP_READ_EN
          S_READ: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_last <= 1'b1;
            end
            if (w_scl_fall) begin
              if (r_last) begin
                sda_out_en <= 1'b0;
                r_last     <= 1'b0;
                r_state    <= S_READ_ACK;
              end else begin
                sda_out_en <= ~r_tx[7];
                r_tx       <= {r_tx[6:0], 1'b0};
              end
            end
          end
          S_READ_ACK: begin
            if (w_scl_rise) begin
              if (r_sda_s2) r_state <= S_IGNORE;
              else          r_mack  <= 1'b1;
            end
            if (w_scl_fall && r_mack) begin
              r_mack     <= 1'b0;
              r_bitcnt   <= 3'd0;
              sda_out_en <= ~port_q[7];
              r_tx       <= {port_q[6:0], 1'b0};
              r_state    <= S_READ;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_i2c_responder.sv
`timescale 1ns/1ps
module tb_lcd_i2c_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       bus_sda;
  logic       sda_out_en;
  logic [7:0] port_q, rx_data;
  logic       rx_cmd_data, rx_half, rx_valid, busy;

  assign bus_sda = m_sda & ~sda_out_en;   // open-drain wired-AND

  always #5 clk = ~clk;

  lcd_i2c_responder dut (
    .clk_1MHz   (clk),
    .rst_n      (rst_n),
    .scl        (m_scl),
    .sda        (bus_sda),
    .sda_out_en (sda_out_en),
    .port_q     (port_q),
    .rx_data    (rx_data),
    .rx_cmd_data(rx_cmd_data),
    .rx_half    (rx_half),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_rx     = 0;
  logic en_seen = 1'b0;

  // Expected decoded events: {half, rs, data}
  logic [9:0] exp_q[$];

  // Reference model of the backpack as seen from the bus
  logic [7:0] m_port = 8'hFF;
  bit         m_phase = 0;
  logic [3:0] m_hi = 4'h0;
  logic       m_rs = 1'b0;
  bit         m_sel = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_port  = 8'hFF;
    m_phase = 0;
    m_sel   = 0;
  endfunction

  function automatic void model_boundary();
    if (m_phase) exp_q.push_back({1'b1, m_rs, m_hi, 4'h0});
    m_phase = 0;
    m_sel   = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] old;
    if (!m_sel) return;
    old = m_port;
    if (old[2] && !b[2] && !old[1]) begin
      if (!m_phase) begin
        m_hi = old[7:4]; m_rs = old[0]; m_phase = 1;
      end else begin
        exp_q.push_back({1'b0, m_rs, m_hi, old[7:4]});
        m_phase = 0;
      end
    end
    m_port = b;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a decoded byte
  always @(negedge clk) begin
    if (sda_out_en) en_seen <= 1'b1;
    if (rst_n && rx_valid) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rx_unexpected: got half=%0b rs=%0b data=0x%02h, expected no event",
                 rx_half, rx_cmd_data, rx_data);
      end else begin
        chk("rx_event", {22'd0, rx_half, rx_cmd_data, rx_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    model_boundary();
    m_sda = 1'b1; clks(4);
    m_scl = 1'b1; clks(8);
    m_sda = 1'b0; clks(8);
    m_scl = 1'b0; clks(4);
  endtask

  task automatic i2c_stop();
    model_boundary();
    m_sda = 1'b0; clks(4);
    m_scl = 1'b1; clks(8);
    m_sda = 1'b1; clks(8);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    clks(4);
    m_scl = 1'b1; clks(8);
    m_scl = 1'b0; clks(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_addr, input string name);
    logic exp_ack, ack;
    if (is_addr) m_sel = (b[7:1] == 7'h27) && !b[0];
    exp_ack = m_sel;
    if (!is_addr) model_byte(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; clks(4);
    m_scl = 1'b1; clks(4);
    ack = ~bus_sda;
    clks(4);
    m_scl = 1'b0; clks(4);
    chk(name, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sda_out_en"}, {31'd0, sda_out_en}, 32'd0);
    chk({tag, "_port_q"}, {24'd0, port_q}, 32'hFF);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, "_rx_flags"}, {29'd0, rx_cmd_data, rx_half, rx_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rx0;
    logic [7:0] b, a;
    int nb;

    // Reset state
    clks(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    clks(5);

    // Directed: full command byte 0xD4
    rx0 = n_rx;
    i2c_start();
    chk("t1_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h4E, 1, "t1_addr_ack");
    send_byte(8'hDC, 0, "t1_b0_ack");
    send_byte(8'hD8, 0, "t1_b1_ack");
    send_byte(8'h4C, 0, "t1_b2_ack");
    send_byte(8'h48, 0, "t1_b3_ack");
    i2c_stop();
    clks(4);
    chk("t1_port_q", {24'd0, port_q}, 32'h48);
    chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    chk("t1_rx_count", n_rx - rx0, 1);

    // Directed: wrong address 0x26
    rx0 = n_rx;
    en_seen = 1'b0;
    i2c_start();
    send_byte(8'h4C, 1, "t2_addr_nack");
    send_byte(8'h3C, 0, "t2_data_nack");
    i2c_stop();
    clks(4);
    chk("t2_sda_never_driven", {31'd0, en_seen}, 32'd0);
    chk("t2_port_q", {24'd0, port_q}, 32'h48);
    chk("t2_rx_count", n_rx - rx0, 0);

    // Directed: lone high nibble flushed at STOP
    rx0 = n_rx;
    i2c_start();
    send_byte(8'h4E, 1, "t3_addr_ack");
    send_byte(8'h3C, 0, "t3_b0_ack");
    send_byte(8'h38, 0, "t3_b1_ack");
    i2c_stop();
    clks(4);
    chk("t3_rx_count", n_rx - rx0, 1);

    // Directed: data byte 0x56 with RW=1 strobe ahead of it
    rx0 = n_rx;
    i2c_start();
    send_byte(8'h4E, 1, "t4_addr_ack");
    send_byte(8'h5E, 0, "t4_rw0_ack");
    send_byte(8'h5A, 0, "t4_rw1_ack");
    send_byte(8'h5D, 0, "t4_b0_ack");
    send_byte(8'h59, 0, "t4_b1_ack");
    send_byte(8'h6D, 0, "t4_b2_ack");
    send_byte(8'h69, 0, "t4_b3_ack");
    i2c_stop();
    clks(4);
    chk("t4_port_q", {24'd0, port_q}, 32'h69);
    chk("t4_rx_count", n_rx - rx0, 1);

    // Read address is refused in the default build
    i2c_start();
    send_byte(8'h4F, 1, "t5_read_nack");
    send_byte(8'hAA, 0, "t5_data_nack");
    i2c_stop();
    clks(4);
    chk("t5_port_q", {24'd0, port_q}, 32'h69);

    // Reset in the middle of a data byte
    i2c_start();
    send_byte(8'h4E, 1, "t6_addr_ack");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    model_reset();
    clks(2);
    chk_reset_outputs("t6_in_reset");
    rst_n = 1'b1;
    clks(5);
    rx0 = n_rx;
    i2c_start();
    send_byte(8'h4E, 1, "t6_addr2_ack");
    send_byte(8'hDC, 0, "t6_b0_ack");
    send_byte(8'hD8, 0, "t6_b1_ack");
    send_byte(8'h4C, 0, "t6_b2_ack");
    send_byte(8'h48, 0, "t6_b3_ack");
    i2c_stop();
    clks(4);
    chk("t6_rx_count", n_rx - rx0, 1);

    // Randomized traffic, with repeated STARTs and stray addresses
    for (int t = 0; t < 25; t++) begin
      i2c_start();
      a = ($urandom_range(0, 9) < 8) ? 8'h4E : 8'($urandom_range(0, 255));
      send_byte(a, 1, "rnd_addr_ack");
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) b[1] = 1'b0;
        send_byte(b, 0, "rnd_data_ack");
      end
      if ($urandom_range(0, 3) != 0) begin
        i2c_stop();
        clks(4);
        chk("rnd_port_q", {24'd0, port_q}, {24'd0, m_port});
      end
    end
    i2c_stop();
    clks(20);
    chk("final_port_q", {24'd0, port_q}, {24'd0, m_port});
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
